// File: rtl/seq_pkg.sv
// Shared constants for the seq_detect_sched scheduler and its round-robin arbiter.
package seq_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int N_REQ      = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational winner plus the tie-break pointer.
module rr_arb2
    import seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_update,
    output logic             o_any,
    output logic             o_winner
);

    // r_rrPtr names the requester that wins a tie; it moves away from every winner.
    logic r_rrPtr;

    always_comb begin
        o_any = |i_req;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = r_rrPtr;
            default: o_winner = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rrPtr <= 1'b0;
        end else if (i_update && o_any) begin
            r_rrPtr <= ~o_winner;
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Shares one bit-serial sequence detector between two requesters: arbitrate,
// serialize the granted word MSB-first, collect the verdict, return a tagged response.
module seq_detect_sched
    import seq_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int RESULT_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_REQ-1:0]  i_req,
    input  logic [WORD_W-1:0] i_data0,
    input  logic [WORD_W-1:0] i_data1,
    output logic [N_REQ-1:0]  o_gnt,
    output logic              o_det_in,
    output logic              o_det_rst,
    input  logic              i_det_match,
    input  logic              i_det_err,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic              o_rsp_match,
    output logic              o_rsp_err
);

    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WAIT_W = $clog2(RESULT_WAIT + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESULT_WAIT - 1);

    logic [2:0]        r_state;
    logic [WORD_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_id;
    logic              r_match;
    logic              r_err;

    logic w_any;
    logic w_winner;
    logic w_detMatch;
    logic w_detErr;

    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_update (r_state == S_IDLE),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // An unknown detector output may only ever count as an error, never as a match.
    assign w_detMatch = (i_det_match === 1'b1);
    assign w_detErr   = (i_det_err !== 1'b0) || ((i_det_match !== 1'b0) && (i_det_match !== 1'b1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_waitCnt <= '0;
            r_id      <= 1'b0;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_winner;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_shift  <= r_id ? i_data1 : i_data0;
                    r_bitCnt <= '0;
                    r_match  <= 1'b0;
                    r_err    <= 1'b0;
                    r_state  <= S_SHIFT;
                end
                // The first shift cycle is the detector leaving its init state, so err is not trusted there.
                S_SHIFT: begin
                    r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                    if (w_detErr && (r_bitCnt != '0)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_bitCnt == BIT_LAST) begin
                        r_waitCnt <= '0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_bitCnt <= r_bitCnt + BIT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (w_detMatch) begin
                        r_match <= 1'b1;
                    end
                    if (w_detErr) begin
                        r_err <= 1'b1;
                    end
                    if (w_detMatch || w_detErr || (r_waitCnt == WAIT_LAST)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    r_match <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt       = (r_state == S_GRANT) ? (N_REQ'(1) << r_id) : '0;
    assign o_det_in    = (r_state == S_SHIFT) && r_shift[WORD_W-1];
    assign o_det_rst   = (r_state != S_SHIFT) && (r_state != S_WAIT);
    assign o_rsp_valid = (r_state == S_DONE);
    assign o_rsp_id    = (r_state == S_DONE) && r_id;
    assign o_rsp_match = (r_state == S_DONE) && r_match;
    assign o_rsp_err   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: a behavioural detector stub plus a
// response scoreboard filled when requests are driven and drained on rsp_valid.
module tb_seq_detect_sched;

    localparam int WORD_W = 8;

    typedef struct {
        logic id;
        logic match;
        logic err;
        int   lat;
        int   nLow;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  data0;
    logic [7:0]  data1;
    logic [1:0]  gnt;
    logic        det_in;
    logic        det_rst;
    logic        det_match = 1'b0;
    logic        det_err = 1'b0;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_match;
    logic        rsp_err;

    rsp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   stubErrAt = -1;
    int   stubMatchAt = -1;
    int   stubIdx = 0;
    logic modelPrio = 1'b0;

    seq_detect_sched #(.WORD_W(WORD_W), .RESULT_WAIT(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_data0     (data0),
        .i_data1     (data1),
        .o_gnt       (gnt),
        .o_det_in    (det_in),
        .o_det_rst   (det_rst),
        .i_det_match (det_match),
        .i_det_err   (det_err),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_match (rsp_match),
        .o_rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Detector stub: stubIdx counts cycles since det_rst fell (0 = first shift cycle).
    always @(negedge clk) begin
        if (det_rst) begin
            stubIdx   <= 0;
            det_match <= 1'b0;
            det_err   <= 1'b0;
        end else begin
            det_err   <= (stubIdx == stubErrAt);
            det_match <= (stubIdx == stubMatchAt);
            stubIdx   <= stubIdx + 1;
        end
    end

    function automatic logic [7:0] msbOrder(input logic [7:0] d);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = d[7-k];
        return r;
    endfunction

    task automatic modelArb(input logic [1:0] r, output logic w);
        w = (r == 2'b11) ? modelPrio : r[1];
        modelPrio = ~w;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelPrio = 1'b0;
    endtask

    // Drives req for one IDLE cycle T; returns at the negedge of T+1 (grant cycle).
    task automatic issue(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        req = r;
        data0 = d0;
        data1 = d1;
        @(negedge clk);
    endtask

    task automatic runToRsp(output bit got, output int lat, output int nLow,
                            output logic [15:0] bits, output logic rId,
                            output logic rMatch, output logic rErr);
        got = 1'b0; lat = 1; nLow = 0; bits = '0;
        rId = 1'b0; rMatch = 1'b0; rErr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1; rId = rsp_id; rMatch = rsp_match; rErr = rsp_err;
                break;
            end
            if (!det_rst && nLow < 16) begin
                bits[nLow] = det_in;
                nLow++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, det_in, det_rst, rsp_valid, rsp_id, rsp_match, rsp_err} !== 8'b00_0_1_0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b want %b", {gnt, det_in, det_rst, rsp_valid, rsp_id, rsp_match, rsp_err}, 8'b00010000);
        end
        rst_n = 1'b1;
        modelPrio = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, det_rst, rsp_valid} !== 4'b00_1_0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got %b want %b", {gnt, det_rst, rsp_valid}, 4'b0010);
        end
    endtask

    task automatic test_basic();
        rsp_t e; bit got; int lat, nLow; logic [15:0] bits; logic rId, rM, rE, w;
        stubErrAt = -1; stubMatchAt = WORD_W;
        modelArb(2'b01, w);
        sbq.push_back('{id: w, match: 1'b1, err: 1'b0, lat: 11, nLow: 9});
        issue(2'b01, 8'b1011_0110, 8'h00);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL basic_gnt: got %b want %b", gnt, 2'b01); end
        req = 2'b00;
        runToRsp(got, lat, nLow, bits, rId, rM, rE);
        e = sbq.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL basic_timeout: got no rsp_valid want rsp_valid"); end
        checks++;
        if (lat != e.lat) begin errors++; $display("[TB] FAIL basic_latency: got %0d want %0d", lat, e.lat); end
        checks++;
        if (nLow != e.nLow) begin errors++; $display("[TB] FAIL basic_low_cycles: got %0d want %0d", nLow, e.nLow); end
        checks++;
        if (bits[8:0] !== {1'b0, msbOrder(8'b1011_0110)}) begin
            errors++; $display("[TB] FAIL basic_bits: got %b want %b", bits[8:0], {1'b0, msbOrder(8'b1011_0110)});
        end
        checks++;
        if ({rId, rM, rE} !== {e.id, e.match, e.err}) begin
            errors++; $display("[TB] FAIL basic_rsp: got %b want %b", {rId, rM, rE}, {e.id, e.match, e.err});
        end
        @(negedge clk);
        checks++;
        if ({det_rst, rsp_valid} !== 2'b10) begin errors++; $display("[TB] FAIL basic_after_done: got %b want %b", {det_rst, rsp_valid}, 2'b10); end
    endtask

    task automatic test_back_to_back();
        rsp_t e; bit got; int lat, nLow; logic [15:0] bits; logic rId, rM, rE, w;
        logic [1:0] gSeen;
        doReset();
        stubErrAt = -1; stubMatchAt = WORD_W;
        for (int i = 0; i < 3; i++) begin
            modelArb(2'b11, w);
            sbq.push_back('{id: w, match: 1'b1, err: 1'b0, lat: 11, nLow: 9});
            issue(2'b11, 8'h3C, 8'hA5);
            gSeen = gnt;
            checks++;
            if (gSeen !== (w ? 2'b10 : 2'b01)) begin
                errors++; $display("[TB] FAIL b2b_gnt%0d: got %b want %b", i, gSeen, (w ? 2'b10 : 2'b01));
            end
            req = 2'b00;
            runToRsp(got, lat, nLow, bits, rId, rM, rE);
            e = sbq.pop_front();
            checks++;
            if (!got || lat != e.lat) begin errors++; $display("[TB] FAIL b2b_latency%0d: got %0d want %0d", i, got ? lat : -1, e.lat); end
            checks++;
            if ({rId, rM, rE} !== {e.id, e.match, e.err} || rId !== gSeen[1]) begin
                errors++; $display("[TB] FAIL b2b_rsp%0d: got %b want %b", i, {rId, rM, rE}, {e.id, e.match, e.err});
            end
        end
    endtask

    task automatic test_err_abort();
        rsp_t e; bit got; int lat, nLow; logic [15:0] bits; logic rId, rM, rE, w;
        logic [7:0] ord;
        stubErrAt = 3; stubMatchAt = -1;
        ord = msbOrder(8'h96);
        modelArb(2'b01, w);
        sbq.push_back('{id: w, match: 1'b0, err: 1'b1, lat: 6, nLow: 4});
        issue(2'b01, 8'h96, 8'h00);
        req = 2'b00;
        runToRsp(got, lat, nLow, bits, rId, rM, rE);
        e = sbq.pop_front();
        checks++;
        if (!got || lat != e.lat) begin errors++; $display("[TB] FAIL abort_latency: got %0d want %0d", got ? lat : -1, e.lat); end
        checks++;
        if (nLow != e.nLow) begin errors++; $display("[TB] FAIL abort_bit_count: got %0d want %0d", nLow, e.nLow); end
        checks++;
        if (bits[3:0] !== ord[3:0]) begin errors++; $display("[TB] FAIL abort_bits: got %b want %b", bits[3:0], ord[3:0]); end
        checks++;
        if ({rId, rM, rE} !== {e.id, e.match, e.err}) begin
            errors++; $display("[TB] FAIL abort_rsp: got %b want %b", {rId, rM, rE}, {e.id, e.match, e.err});
        end
        @(negedge clk);
        checks++;
        if (det_rst !== 1'b1) begin errors++; $display("[TB] FAIL abort_det_rst: got %b want 1", det_rst); end
    endtask

    task automatic test_timeout();
        rsp_t e; bit got; int lat, nLow; logic [15:0] bits; logic rId, rM, rE, w;
        stubErrAt = -1; stubMatchAt = -1;
        modelArb(2'b10, w);
        sbq.push_back('{id: w, match: 1'b0, err: 1'b0, lat: 12, nLow: 10});
        issue(2'b10, 8'h00, 8'h5A);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL timeout_gnt: got %b want %b", gnt, 2'b10); end
        req = 2'b00;
        runToRsp(got, lat, nLow, bits, rId, rM, rE);
        e = sbq.pop_front();
        checks++;
        if (!got || lat != e.lat) begin errors++; $display("[TB] FAIL timeout_latency: got %0d want %0d", got ? lat : -1, e.lat); end
        checks++;
        if (bits[7:0] !== msbOrder(8'h5A)) begin errors++; $display("[TB] FAIL timeout_bits: got %b want %b", bits[7:0], msbOrder(8'h5A)); end
        checks++;
        if ({rId, rM, rE} !== {e.id, e.match, e.err}) begin
            errors++; $display("[TB] FAIL timeout_rsp: got %b want %b", {rId, rM, rE}, {e.id, e.match, e.err});
        end
    endtask

    task automatic test_err_first_cycle();
        rsp_t e; bit got; int lat, nLow; logic [15:0] bits; logic rId, rM, rE, w;
        stubErrAt = 0; stubMatchAt = WORD_W;
        modelArb(2'b01, w);
        sbq.push_back('{id: w, match: 1'b1, err: 1'b0, lat: 11, nLow: 9});
        issue(2'b01, 8'hE7, 8'h00);
        req = 2'b00;
        runToRsp(got, lat, nLow, bits, rId, rM, rE);
        e = sbq.pop_front();
        checks++;
        if (!got || lat != e.lat || nLow != e.nLow) begin
            errors++; $display("[TB] FAIL err0_length: got lat %0d low %0d want lat %0d low %0d", got ? lat : -1, nLow, e.lat, e.nLow);
        end
        checks++;
        if (bits[7:0] !== msbOrder(8'hE7)) begin errors++; $display("[TB] FAIL err0_bits: got %b want %b", bits[7:0], msbOrder(8'hE7)); end
        checks++;
        if ({rId, rM, rE} !== {e.id, e.match, e.err}) begin
            errors++; $display("[TB] FAIL err0_rsp: got %b want %b", {rId, rM, rE}, {e.id, e.match, e.err});
        end
        stubErrAt = -1;
    endtask

    task automatic test_reset_midshift();
        rsp_t e; bit got; int lat, nLow; logic [15:0] bits; logic rId, rM, rE, w;
        int spurious;
        stubErrAt = -1; stubMatchAt = WORD_W;
        modelArb(2'b01, w);
        issue(2'b01, 8'hC3, 8'h00);
        req = 2'b00;
        repeat (6) @(negedge clk);
        checks++;
        if ({det_rst, det_in} !== 2'b00) begin errors++; $display("[TB] FAIL mid_shift5: got %b want %b", {det_rst, det_in}, 2'b00); end
        #2 rst_n = 1'b0;
        #1;
        modelPrio = 1'b0;
        checks++;
        if ({gnt, det_in, det_rst, rsp_valid, rsp_id, rsp_match, rsp_err} !== 8'b00_0_1_0000) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got %b want %b", {gnt, det_in, det_rst, rsp_valid, rsp_id, rsp_match, rsp_err}, 8'b00010000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("[TB] FAIL mid_no_rsp: got %0d want 0", spurious); end
        modelArb(2'b11, w);
        sbq.push_back('{id: w, match: 1'b1, err: 1'b0, lat: 11, nLow: 9});
        issue(2'b11, 8'h81, 8'h42);
        checks++;
        if (gnt !== (w ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL mid_regrant: got %b want %b", gnt, (w ? 2'b10 : 2'b01)); end
        req = 2'b00;
        runToRsp(got, lat, nLow, bits, rId, rM, rE);
        e = sbq.pop_front();
        checks++;
        if (!got || lat != e.lat || {rId, rM, rE} !== {e.id, e.match, e.err}) begin
            errors++; $display("[TB] FAIL mid_next_rsp: got lat %0d rsp %b want lat %0d rsp %b", got ? lat : -1, {rId, rM, rE}, e.lat, {e.id, e.match, e.err});
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_empty: got %0d want 0", sbq.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        data0 = 8'h00;
        data1 = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_err_abort();
        test_timeout();
        test_err_first_cycle();
        test_reset_midshift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
